input_debouncer: RTL and testbench

Multi-channel button conditioner between the raw button sources (gamepad decoder outputs, spare ui_in pins) and the player/AI controllers. Each channel gets a synchroniser, a debounce filter clocked by the per-frame countdown enable (the registered vpos-bit-5 rising-edge pulse from graphics), and single-cycle press/release pulses. Channels can also emit auto-repeat pulses while held, for the start/menu inputs.

---
 rtl/input_debouncer_if.sv | 38 +++
 rtl/input_debouncer.sv | 123 ++++++++++++
 tb/tb_input_debouncer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Button conditioner bus: the countdown tick and raw levels in, the
// conditioned levels and event pulses out.
// Ports: i_countdown_en  frame tick
//        i_raw           raw button levels
//        o_level         debounced levels
//        o_press         rise pulses
//        o_release       fall pulses
//        o_repeat        auto-repeat pulses
interface input_debouncer_if #(
  parameter int NUM_CH = 3
);
  logic              i_countdown_en;
  logic [NUM_CH-1:0] i_raw;
  logic [NUM_CH-1:0] o_level;
  logic [NUM_CH-1:0] o_press;
  logic [NUM_CH-1:0] o_release;
  logic [NUM_CH-1:0] o_repeat;

  // Source side: drives the tick and the raw buttons, consumes the events.
  modport master (
    output i_countdown_en,
    output i_raw,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_repeat
  );

  // Conditioner side.
  modport slave (
    input  i_countdown_en,
    input  i_raw,
    output o_level,
    output o_press,
    output o_release,
    output o_repeat
  );
endinterface

// File: rtl/input_debouncer.sv
// Purpose: per-channel sync, tick-based debounce, press/release/repeat pulses.
// Latency: 2 clk sync, then the level flips on the DEBOUNCE_TICKS-th tick seen while the input differs.
// Backpressure: none; every output is a registered level or one-clock pulse.
// Ports: clk, rst (sync, active high); bus = input_debouncer_if.slave
//        (i_countdown_en, i_raw in; o_level, o_press, o_release, o_repeat out).
module input_debouncer #(
  parameter int NUM_CH         = 3,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_PERIOD  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input_debouncer_if.slave   bus
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [8:0]    RD9      = 9'(REPEAT_DELAY);
  localparam logic [8:0]    RP9      = 9'(REPEAT_PERIOD);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15) begin : g_bad_debounce
    $error("input_debouncer: DEBOUNCE_TICKS must be 1..15");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 255) begin : g_bad_delay
    $error("input_debouncer: REPEAT_DELAY must be 1..255");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_bad_period
    $error("input_debouncer: REPEAT_PERIOD must be 1..255");
  end

  logic                       tick;
  logic [NUM_CH-1:0]          sync1_q;
  logic [NUM_CH-1:0]          sync2_q;
  logic [NUM_CH-1:0]          level_q;
  logic [NUM_CH-1:0]          press_q;
  logic [NUM_CH-1:0]          release_q;
  logic [NUM_CH-1:0]          repeat_q;
  logic [NUM_CH-1:0]          first_q;
  logic [NUM_CH-1:0][CW-1:0]  cnt_q;
  logic [NUM_CH-1:0][7:0]     rc_q;

  logic [NUM_CH-1:0]          differ;
  logic [NUM_CH-1:0]          cnt_one;
  logic [NUM_CH-1:0]          flip;
  logic [NUM_CH-1:0]          fall;
  logic [NUM_CH-1:0][8:0]     rc_inc;

  assign tick = bus.i_countdown_en;

  always_comb begin
    cnt_one = '0;
    rc_inc  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_one[ch] = (cnt_q[ch] == CNT_ONE);
      // 9 bits so the compare against REPEAT_DELAY/PERIOD can't alias on wrap.
      rc_inc[ch]  = {1'b0, rc_q[ch]} + 9'd1;
    end
  end

  // flip: this edge commits the synchronised level; fall: that commit is a release.
  assign differ = sync2_q ^ level_q;
  assign flip   = differ & cnt_one & {NUM_CH{tick}};
  assign fall   = flip & level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      first_q   <= '1;
      cnt_q     <= {NUM_CH{CNT_LOAD}};
      rc_q      <= '0;
    end else begin
      sync1_q   <= bus.i_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_q ^ flip;
      press_q   <= flip & sync2_q;
      release_q <= fall;

      for (int ch = 0; ch < NUM_CH; ch++) begin
        // Debounce: any return to the committed level restarts the count.
        if (!differ[ch] || flip[ch]) begin
          cnt_q[ch] <= CNT_LOAD;
        end else if (tick) begin
          cnt_q[ch] <= cnt_q[ch] - CNT_ONE;
        end

        // Auto-repeat only counts ticks after the press edge; the release
        // edge itself clears state so it never coincides with a repeat.
        if (!level_q[ch] || fall[ch]) begin
          rc_q[ch]     <= '0;
          first_q[ch]  <= 1'b1;
          repeat_q[ch] <= 1'b0;
        end else if (tick) begin
          if (first_q[ch] && rc_inc[ch] == RD9) begin
            repeat_q[ch] <= 1'b1;
            rc_q[ch]     <= '0;
            first_q[ch]  <= 1'b0;
          end else if (!first_q[ch] && rc_inc[ch] == RP9) begin
            repeat_q[ch] <= 1'b1;
            rc_q[ch]     <= '0;
          end else begin
            repeat_q[ch] <= 1'b0;
            rc_q[ch]     <= rc_inc[ch][8] ? 8'hFF : rc_inc[ch][7:0];
          end
        end else begin
          repeat_q[ch] <= 1'b0;
        end
      end
    end
  end

  assign bus.o_level   = level_q;
  assign bus.o_press   = press_q;
  assign bus.o_release = release_q;
  assign bus.o_repeat  = repeat_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed button scenarios followed by random
// presses, bounces, ticks and resets. An event-level model predicts every
// press/release/repeat pulse with its cycle; a monitor matches DUT pulses.
module tb_input_debouncer;
  localparam int NCH = 3;
  localparam int DT  = 4;
  localparam int RD  = 16;
  localparam int RP  = 4;

  typedef struct {
    int cyc;
    int ch;
    int kind;   // 0 press, 1 release, 2 repeat
  } ev_t;

  logic           clk;
  logic           rst;
  logic           tick;
  logic [NCH-1:0] raw;
  int             tick_mode;
  int             tick_ctr;
  int             cyc;
  int             errors;
  int             checks;
  ev_t            exp_q[$];
  string          kind_name[3];

  // Model state
  logic [NCH-1:0] m_s1, m_s2, m_level;
  int             m_run  [NCH];
  int             m_held [NCH];

  input_debouncer_if #(.NUM_CH(NCH)) bus ();

  assign bus.i_raw          = raw;
  assign bus.i_countdown_en = tick;

  input_debouncer #(
    .NUM_CH(NCH), .DEBOUNCE_TICKS(DT), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  function automatic void push_ev(input int ch, input int kind);
    ev_t e;
    e.cyc  = cyc;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endfunction

  // Tick source: off, every 8 clocks, or random.
  initial begin
    tick = 1'b0;
    tick_ctr = 0;
    forever begin
      @(negedge clk);
      tick_ctr++;
      case (tick_mode)
        1:       tick = (tick_ctr % 8 == 0);
        2:       tick = ($urandom_range(0, 2) == 0);
        default: tick = 1'b0;
      endcase
    end
  end

  // Reference model: a level flips when the synchronised input has differed
  // for DT ticks in a row; repeats fall on the RD-th tick held after a press
  // and every RP ticks after that.
  initial begin
    bit flip;
    cyc = 0;
    m_s1 = '0; m_s2 = '0; m_level = '0;
    for (int ch = 0; ch < NCH; ch++) begin m_run[ch] = 0; m_held[ch] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_level = '0;
        for (int ch = 0; ch < NCH; ch++) begin m_run[ch] = 0; m_held[ch] = 0; end
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          flip = 1'b0;
          if (m_s2[ch] != m_level[ch]) begin
            if (tick) m_run[ch]++;
            if (m_run[ch] == DT) flip = 1'b1;
          end else begin
            m_run[ch] = 0;
          end
          if (m_level[ch] && !flip && tick) begin
            m_held[ch]++;
            if (m_held[ch] == RD || (m_held[ch] > RD && (m_held[ch] - RD) % RP == 0))
              push_ev(ch, 2);
          end
          if (flip) begin
            m_level[ch] = m_s2[ch];
            push_ev(ch, m_s2[ch] ? 0 : 1);
            m_run[ch]  = 0;
            m_held[ch] = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = raw;
      end
    end
  end

  // Monitor: every DUT pulse must match the next expected event exactly.
  initial begin
    ev_t e;
    logic [NCH-1:0] pulses [3];
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_%s ch%0d: expected at cycle %0d, absent through cycle %0d",
                 kind_name[e.kind], e.ch, e.cyc, cyc);
      end
      pulses[0] = bus.o_press;
      pulses[1] = bus.o_release;
      pulses[2] = bus.o_repeat;
      for (int ch = 0; ch < NCH; ch++) begin
        for (int k = 0; k < 3; k++) begin
          if (pulses[k][ch] === 1'b1) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_%s ch%0d at cycle %0d: got pulse, expected none",
                       kind_name[k], ch, cyc);
            end else begin
              e = exp_q.pop_front();
              check_eq($sformatf("event_%s_ch%0d(cyc*16+ch*4+kind)", kind_name[k], ch),
                       cyc * 16 + ch * 4 + k, e.cyc * 16 + e.ch * 4 + e.kind);
            end
          end else if (pulses[k][ch] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s ch%0d at cycle %0d: got X/Z, expected 0/1", kind_name[k], ch, cyc);
          end
        end
      end
      check_eq("o_level", int'(bus.o_level), int'(m_level));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    kind_name[0] = "press";
    kind_name[1] = "release";
    kind_name[2] = "repeat";
    errors = 0;
    checks = 0;
    tick_mode = 0;
    rst = 1'b1;
    raw = 3'b111;

    // Reset with buttons held, then no ticks: nothing may happen.
    wait_clk(3);
    rst = 1'b0;
    wait_clk(100);
    raw = 3'b000;
    wait_clk(10);
    tick_mode = 1;
    wait_clk(40);

    // Clean press on channel 0.
    raw[0] = 1'b1;
    wait_clk(50);

    // Bounce on channel 1: high for 2 ticks, low for one clock, then held.
    raw[1] = 1'b1;
    wait_clk(16);
    raw[1] = 1'b0;
    wait_clk(1);
    raw[1] = 1'b1;
    wait_clk(50);

    // Release channel 0.
    raw[0] = 1'b0;
    wait_clk(50);

    // Auto-repeat on channel 2, then release.
    raw[2] = 1'b1;
    wait_clk((RD + 5 * RP) * 8 + 40);
    raw[2] = 1'b0;
    wait_clk(80);

    // Simultaneous press on channels 0 and 2.
    raw = 3'b000;
    wait_clk(60);
    raw = 3'b101;
    wait_clk(60);

    // Reset in the middle of a press on channel 1.
    raw = 3'b000;
    wait_clk(60);
    raw[1] = 1'b1;
    wait_clk(20);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(60);

    // Random phase.
    tick_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) raw[$urandom_range(0, NCH - 1)] ^= 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      wait_clk(1);
    end
    rst = 1'b0;
    tick_mode = 0;
    wait_clk(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events still outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
